// File: rtl/microarchtrace_pkg.sv
// rtl/microarchtrace_pkg.sv - shared types for the microarchitecture trace event arbiter
package microarchtrace_pkg;

    typedef enum logic [2:0] {
        EV_WB        = 3'd0,
        EV_WB_DONE   = 3'd1,
        EV_IDEX      = 3'd2,
        EV_IDEX_DONE = 3'd3,
        EV_IF        = 3'd4,
        EV_IF_START  = 3'd5,
        EV_IF_END    = 3'd6,
        EV_RSVD      = 3'd7
    } ev_kind_e;

    localparam int EV_NUM = 7;

    typedef struct packed {
        logic [EV_NUM-1:0] mask;
        logic [31:0]       wb_pc;
        logic [31:0]       idex_pc;
        logic [31:0]       fetch_pc;
        logic [31:0]       insn;
        logic [1:0]        mode;
        logic              c;
        logic [15:0]       c_insn;
    } ev_bundle_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } drain_state_e;

    // Lowest set bit wins, which is the fixed stage priority order.
    function automatic ev_kind_e lowest_kind(input logic [EV_NUM-1:0] m);
        ev_kind_e k;
        k = EV_WB;
        for (int i = EV_NUM - 1; i >= 0; i--) begin
            if (m[i]) begin
                k = ev_kind_e'(i[2:0]);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/microarchtrace_fifo.sv
// rtl/microarchtrace_fifo.sv - synchronous bundle FIFO with head and next-head peek ports
module microarchtrace_fifo
    import microarchtrace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  ev_bundle_t               push_data_i,
    input  logic                     pop_i,
    output ev_bundle_t               head_o,
    output logic [EV_NUM-1:0]        next_mask_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    ev_bundle_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   rd_next;
    logic            pop_eff;

    assign pop_eff = pop_i && (count_q != '0);
    assign rd_next = rd_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_next;
        end
        if (push_i && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign next_mask_o = mem_q[rd_next].mask;
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = count_q[AW];

endmodule

// File: rtl/microarchtrace_event_arbiter.sv
// rtl/microarchtrace_event_arbiter.sv - serialises per-cycle trace event bundles into one event stream
module microarchtrace_event_arbiter
    import microarchtrace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        ev_mask_i,
    input  logic [31:0]       wb_pc_i,
    input  logic [31:0]       idex_pc_i,
    input  logic [31:0]       fetch_pc_i,
    input  logic [31:0]       fetch_insn_i,
    input  logic [1:0]        fetch_mode_i,
    input  logic              fetch_c_i,
    input  logic [15:0]       fetch_c_insn_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2:0]        out_kind_o,
    output logic [31:0]       out_pc_o,
    output logic [31:0]       out_insn_o,
    output logic [1:0]        out_mode_o,
    output logic              out_c_o,
    output logic [15:0]       out_c_insn_o,
    output logic              out_lost_o,
    output logic [SEQ_W-1:0]  out_seq_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    drain_state_e        state_q, state_d;
    logic [EV_NUM-1:0]   rem_q, rem_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [15:0]         drop_q, drop_d;
    logic                lost_q, lost_d;

    ev_bundle_t          in_bundle;
    ev_bundle_t          head;
    logic [EV_NUM-1:0]   next_mask;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    logic                emit;
    logic                capture;
    logic                handshake;
    logic [EV_NUM-1:0]   rem_clr;
    logic                pop;
    logic                push_ok;
    logic                drop;
    ev_kind_e            cur_kind;

    assign in_bundle = '{
        mask:     ev_mask_i,
        wb_pc:    wb_pc_i,
        idex_pc:  idex_pc_i,
        fetch_pc: fetch_pc_i,
        insn:     fetch_insn_i,
        mode:     fetch_mode_i,
        c:        fetch_c_i,
        c_insn:   fetch_c_insn_i
    };

    assign emit      = (state_q == ST_EMIT);
    assign capture   = (ev_mask_i != '0);
    assign handshake = emit && out_ready_i;
    assign rem_clr   = rem_q & (rem_q - 1'b1);
    assign pop       = handshake && (rem_clr == '0);
    // A full FIFO still takes the push when its head leaves on the same edge.
    assign push_ok   = capture && (!fifo_full || pop);
    assign drop      = capture && !push_ok;
    assign cur_kind  = lowest_kind(rem_q);

    microarchtrace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_ok),
        .push_data_i (in_bundle),
        .pop_i       (pop),
        .head_o      (head),
        .next_mask_o (next_mask),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        lost_d  = lost_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_EMIT;
                    rem_d   = head.mask;
                end
            end
            ST_EMIT: begin
                if (handshake) begin
                    seq_d = seq_q + 1'b1;
                    if (rem_clr != '0) begin
                        rem_d = rem_clr;
                    end else if (fifo_count != CNT_W'(1)) begin
                        rem_d = next_mask;
                    end else begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase

        if (handshake) begin
            lost_d = 1'b0;
        end
        if (drop) begin
            lost_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            lost_q  <= lost_d;
        end
    end

    // Payload is decoded from the FIFO head and the remaining mask, both registered.
    always_comb begin
        out_valid_o  = emit;
        out_kind_o   = 3'd0;
        out_pc_o     = '0;
        out_insn_o   = '0;
        out_mode_o   = '0;
        out_c_o      = 1'b0;
        out_c_insn_o = '0;
        if (emit) begin
            out_kind_o = cur_kind;
            case (cur_kind)
                EV_WB, EV_WB_DONE:     out_pc_o = head.wb_pc;
                EV_IDEX, EV_IDEX_DONE: out_pc_o = head.idex_pc;
                EV_IF, EV_IF_END:      out_pc_o = head.fetch_pc;
                default:               out_pc_o = '0;
            endcase
            if (cur_kind == EV_IF || cur_kind == EV_IF_END) begin
                out_insn_o   = head.insn;
                out_mode_o   = head.mode;
                out_c_o      = head.c;
                out_c_insn_o = head.c_insn;
            end
        end
    end

    assign out_lost_o = emit && lost_q;
    assign out_seq_o  = seq_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_microarchtrace_event_arbiter.sv
// tb/tb_microarchtrace_event_arbiter.sv - directed self-checking bench for the trace event arbiter
module tb_microarchtrace_event_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  ev_mask_i;
    logic [31:0] wb_pc_i, idex_pc_i, fetch_pc_i, fetch_insn_i;
    logic [1:0]  fetch_mode_i;
    logic        fetch_c_i;
    logic [15:0] fetch_c_insn_i;
    logic        out_valid_o, out_ready_i;
    logic [2:0]  out_kind_o;
    logic [31:0] out_pc_o, out_insn_o;
    logic [1:0]  out_mode_o;
    logic        out_c_o;
    logic [15:0] out_c_insn_o;
    logic        out_lost_o;
    logic [15:0] out_seq_o;
    logic [15:0] drop_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_seq = 0;

    always #5 clk = ~clk;

    microarchtrace_event_arbiter #(.DEPTH(8), .SEQ_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ev_mask_i      (ev_mask_i),
        .wb_pc_i        (wb_pc_i),
        .idex_pc_i      (idex_pc_i),
        .fetch_pc_i     (fetch_pc_i),
        .fetch_insn_i   (fetch_insn_i),
        .fetch_mode_i   (fetch_mode_i),
        .fetch_c_i      (fetch_c_i),
        .fetch_c_insn_i (fetch_c_insn_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_kind_o     (out_kind_o),
        .out_pc_o       (out_pc_o),
        .out_insn_o     (out_insn_o),
        .out_mode_o     (out_mode_o),
        .out_c_o        (out_c_o),
        .out_c_insn_o   (out_c_insn_o),
        .out_lost_o     (out_lost_o),
        .out_seq_o      (out_seq_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks the presented event, which the bench expects to be accepted next edge.
    task automatic chk_ev(input string tag, input logic [2:0] kind, input logic [31:0] pc,
                          input logic [31:0] insn, input logic lost);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'(1));
        chk({tag, "_kind"}, 64'(out_kind_o), 64'(kind));
        chk({tag, "_pc"}, 64'(out_pc_o), 64'(pc));
        chk({tag, "_insn"}, 64'(out_insn_o), 64'(insn));
        chk({tag, "_lost"}, 64'(out_lost_o), 64'(lost));
        chk({tag, "_seq"}, 64'(out_seq_o), 64'(exp_seq));
        exp_seq++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'(0));
        chk({tag, "_kind"}, 64'(out_kind_o), 64'(0));
        chk({tag, "_pc"}, 64'(out_pc_o), 64'(0));
        chk({tag, "_insn"}, 64'(out_insn_o), 64'(0));
        chk({tag, "_mode"}, 64'(out_mode_o), 64'(0));
        chk({tag, "_c"}, 64'(out_c_o), 64'(0));
        chk({tag, "_cinsn"}, 64'(out_c_insn_o), 64'(0));
        chk({tag, "_lost"}, 64'(out_lost_o), 64'(0));
        chk({tag, "_seq"}, 64'(out_seq_o), 64'(0));
        chk({tag, "_drop"}, 64'(drop_cnt_o), 64'(0));
    endtask

    task automatic set_bundle(input logic [6:0] m, input logic [31:0] wpc);
        ev_mask_i      = m;
        wb_pc_i        = wpc;
        idex_pc_i      = 32'h200;
        fetch_pc_i     = 32'h300;
        fetch_insn_i   = 32'h1111_1111;
        fetch_mode_i   = 2'd3;
        fetch_c_i      = 1'b1;
        fetch_c_insn_i = 16'hABCD;
    endtask

    initial begin
        rst_n       = 1'b0;
        out_ready_i = 1'b0;
        set_bundle(7'd0, 32'h0);
        step();
        step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();

        // Single bundle WB+IDEX+IF with ready held high
        set_bundle(7'b0010101, 32'h100);
        out_ready_i = 1'b1;
        step();
        ev_mask_i = 7'd0;
        chk("t1_no_bypass", 64'(out_valid_o), 64'(0));
        step();
        chk_ev("t1_ev0", 3'd0, 32'h100, 32'h0, 1'b0);
        chk("t1_ev0_mode", 64'(out_mode_o), 64'(0));
        step();
        chk_ev("t1_ev1", 3'd2, 32'h200, 32'h0, 1'b0);
        step();
        chk_ev("t1_ev2", 3'd4, 32'h300, 32'h1111_1111, 1'b0);
        chk("t1_ev2_mode", 64'(out_mode_o), 64'(3));
        chk("t1_ev2_c", 64'(out_c_o), 64'(1));
        chk("t1_ev2_cinsn", 64'(out_c_insn_o), 64'(16'hABCD));
        step();
        chk("t1_idle", 64'(out_valid_o), 64'(0));

        // Backpressure: head event must hold for five stalled cycles
        out_ready_i = 1'b0;
        set_bundle(7'b0010101, 32'h100);
        step();
        ev_mask_i = 7'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 64'(out_valid_o), 64'(1));
            chk("t2_hold_kind", 64'(out_kind_o), 64'(0));
            chk("t2_hold_pc", 64'(out_pc_o), 64'(32'h100));
            chk("t2_hold_seq", 64'(out_seq_o), 64'(exp_seq));
            step();
        end
        out_ready_i = 1'b1;
        chk_ev("t2_ev0", 3'd0, 32'h100, 32'h0, 1'b0);
        step();
        chk_ev("t2_ev1", 3'd2, 32'h200, 32'h0, 1'b0);
        step();
        chk_ev("t2_ev2", 3'd4, 32'h300, 32'h1111_1111, 1'b0);
        step();
        chk("t2_idle", 64'(out_valid_o), 64'(0));

        // Overflow: ten pushes into an eight-deep FIFO with the sink stalled
        out_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_bundle(7'b0000001, 32'(i));
            step();
        end
        ev_mask_i = 7'd0;
        chk("t3_drop_cnt", 64'(drop_cnt_o), 64'(2));
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_ev("t3_ev", 3'd0, 32'(i), 32'h0, (i == 0));
            step();
        end
        chk("t3_idle", 64'(out_valid_o), 64'(0));

        // Full FIFO: last bit of head pops in the same cycle as a new push
        out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_bundle(7'b0000001, 32'h40 + 32'(i));
            step();
        end
        chk("t4_full_head_pc", 64'(out_pc_o), 64'(32'h40));
        set_bundle(7'b0000001, 32'h99);
        out_ready_i = 1'b1;
        chk_ev("t4_ev_head", 3'd0, 32'h40, 32'h0, 1'b0);
        step();
        ev_mask_i = 7'd0;
        chk("t4_drop_unchanged", 64'(drop_cnt_o), 64'(2));
        for (int i = 1; i < 8; i++) begin
            chk_ev("t4_ev", 3'd0, 32'h40 + 32'(i), 32'h0, 1'b0);
            step();
        end
        chk_ev("t4_ev_new", 3'd0, 32'h99, 32'h0, 1'b0);
        step();
        chk("t4_idle", 64'(out_valid_o), 64'(0));

        // Payload muxing for IF_START and IF_END
        set_bundle(7'b1100000, 32'h555);
        fetch_pc_i   = 32'h80;
        fetch_insn_i = 32'h00A0_0093;
        step();
        ev_mask_i = 7'd0;
        step();
        chk_ev("t5_if_start", 3'd5, 32'h0, 32'h0, 1'b0);
        chk("t5_if_start_mode", 64'(out_mode_o), 64'(0));
        chk("t5_if_start_cinsn", 64'(out_c_insn_o), 64'(0));
        step();
        chk_ev("t5_if_end", 3'd6, 32'h80, 32'h00A0_0093, 1'b0);
        chk("t5_if_end_mode", 64'(out_mode_o), 64'(3));
        step();
        chk("t5_idle", 64'(out_valid_o), 64'(0));

        // Reset mid-drain with three bundles queued
        out_ready_i = 1'b0;
        set_bundle(7'h7F, 32'h700);
        step();
        step();
        step();
        chk("t6_busy", 64'(out_valid_o), 64'(1));
        rst_n = 1'b0;
        step();
        chk_reset_vals("t6_reset");
        rst_n       = 1'b1;
        ev_mask_i   = 7'd0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_no_stale", 64'(out_valid_o), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microarchtrace_event_arbiter.md
# microarchtrace_event_arbiter

- Serialises the per-cycle trace events of the ibex microarchitecture trace into one valid/ready event stream, one event per transfer.
- Events can arrive from WB, ID/EX and IF in the same cycle. The block stores each cycle's events as a bundle in a FIFO, then drains each bundle in fixed stage priority order.
- It sits between the trace event qualifier and a hardware trace sink, and replaces per-event DPI calls.
- Bundles that arrive while the FIFO is full are dropped, and the drop is reported.

## Interface
- `DEPTH`, default 8: FIFO depth in bundles; power of two, ≥2.
- `SEQ_W`, default 16: sequence counter width.
- `clk` in 1: clock, all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ev_mask_i` in 7: qualified event strobes for this cycle, bit index = `ev_kind_e`.
- `wb_pc_i` in 32: PC for WB and WB_DONE.
- `idex_pc_i` in 32: PC for IDEX and IDEX_DONE.
- `fetch_pc_i` in 32: PC for IF and IF_END.
- `fetch_insn_i` in 32: fetched instruction.
- `fetch_mode_i` in 2: privilege mode.
- `fetch_c_i` in 1: compressed-instruction flag.
- `fetch_c_insn_i` in 16: compressed encoding.
- `out_valid_o` out 1: event available.
- `out_ready_i` in 1: sink accepts the event.
- `out_kind_o` out 3: `ev_kind_e` of the event.
- `out_pc_o` out 32, `out_insn_o` out 32, `out_mode_o` out 2, `out_c_o` out 1, `out_c_insn_o` out 16: event payload.
- `out_lost_o` out 1: at least one bundle was dropped before this event.
- `out_seq_o` out `SEQ_W`: sequence number of this event.
- `drop_cnt_o` out 16: count of dropped bundles, saturating.

## Operation
- Event kinds, in priority order: WB=0, WB_DONE=1, IDEX=2, IDEX_DONE=3, IF=4, IF_START=5, IF_END=6. Kind 7 is reserved.
- **Capture.**
  - If `ev_mask_i`≠0, one bundle is captured: the mask plus all payload inputs.
  - A zero mask is never stored.
- **Push and drop rule.**
  - The push is accepted if `count<DEPTH`, or if the head bundle pops in the same cycle.
  - Otherwise the bundle is dropped: `drop_cnt_o` increments, saturating at 0xFFFF, and `lost_pending` is set.
- **Drain FSM**, states IDLE and EMIT.
  - IDLE → EMIT when the FIFO is non-empty. The head mask is loaded into the `remaining` register.
  - In EMIT, the lowest set bit of `remaining` selects `out_kind_o`.
  - On an `out_valid_o && out_ready_i` handshake, that bit is cleared and `out_seq_o` increments (wraps).
  - When the last bit clears, the head pops. Next state is EMIT with the new head loaded if another bundle is queued, otherwise IDLE.
- **Payload selection.**
  - WB and WB_DONE use `wb_pc`. IDEX and IDEX_DONE use `idex_pc`. IF and IF_END use `fetch_pc`.
  - IF_START: pc=0.
  - insn, mode, c and c_insn carry bundle values for IF and IF_END only; they are 0 for all other kinds.
- **Lost flag.**
  - `out_lost_o` = `lost_pending` while EMIT.
  - `lost_pending` clears on the handshake that presents it.
  - A drop in that same cycle keeps it set.

## Timing
- Reset values:
  - `out_valid_o`=0; `out_kind_o`, `out_pc_o`, `out_insn_o`, `out_mode_o`, `out_c_o`, `out_c_insn_o`=0.
  - `out_lost_o`=0, `out_seq_o`=0, `drop_cnt_o`=0.
  - FIFO empty, FSM in IDLE.
- Reset asserted mid-drain discards all queued events on the same edge. `ev_mask_i` is ignored while `rst_n`=0.
- Latency: a bundle pushed into an empty FIFO at edge N gives `out_valid_o`=1 after edge N+1. There is no combinational bypass.
- Output hold: `out_valid_o` and all payload outputs stay stable until the handshake. `out_valid_o` never drops without a handshake.
- Throughput: one event per cycle with `out_ready_i` held at 1, including across bundle boundaries (back-to-back pop and load).
- Outputs are registered or decoded only from registered state. There is no combinational path from `out_ready_i` to `out_valid_o`.

## Structure
- `microarchtrace_pkg` holds:
  - `ev_kind_e` (3-bit enum);
  - `EV_NUM`=7;
  - `ev_bundle_t` (packed struct: mask, wb_pc, idex_pc, fetch_pc, insn, mode, c, c_insn);
  - the drain FSM state enum.
- Sub-module `microarchtrace_fifo`:
  - synchronous FIFO of `ev_bundle_t`, parameter `DEPTH`;
  - push/pop ports, full/empty flags, registered count.
- The top level contains the FSM, the priority encoder, the payload mux and the counters.

## Test plan
- Single bundle: mask 0b0010101 (WB, IDEX, IF), `out_ready_i`=1 → kinds 0, 2, 4 on three consecutive cycles; `out_seq_o` 0, 1, 2; first valid one cycle after the push.
- Backpressure: the same bundle with `out_ready_i`=0 for 5 cycles → kind 0 and its payload held unchanged; then kinds 0, 2, 4 drain after ready rises.
- Overflow: `DEPTH`=8, `out_ready_i`=0, 10 consecutive non-zero masks → `drop_cnt_o`=2; the first event afterwards has `out_lost_o`=1 and later events have 0.
- Full with simultaneous pop: FIFO full, last bit of the head handshakes in the same cycle as a new push → push accepted, `drop_cnt_o` unchanged.
- Payload muxing: IF_START and IF_END in one bundle, fetch_pc 0x80, insn 0x00A00093 → IF_START with pc 0 and insn 0, then IF_END with pc 0x80 and insn 0x00A00093.
- Reset mid-drain: 3 bundles queued, `rst_n`=0 for 1 cycle → all outputs at reset values the next cycle, and no stale events after release.
